clock_div_ctrl: RTL

//  Run-time controller for a programmable clock divider. Owns the active divide

---
 rtl/clock_div_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/clock_div_ctrl.sv
// Run-time controller for a programmable clock divider: owns the active divide value,
// accepts new values over valid/ready and swaps them in only at a falling-edge boundary.
module clock_div_ctrl #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] MIN_DIV   = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(1)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic running;
  logic at_end;
  logic boundary;
  logic xfer;
  logic legal;

  assign running   = (state_q != IDLE);
  assign at_end    = (counter_q >= active_q);
  assign boundary  = at_end && clk_q;
  assign div_ready = (state_q != PEND);
  assign xfer      = div_valid && div_ready;
  assign legal     = (div_value >= MIN_DIV);

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    counter_d = counter_q;
    clk_d     = clk_q;
    cfg_err_d = xfer && !legal;

    // The divider keeps running in every non-idle state; a boundary toggle
    // naturally lands clk_out at 0 with the counter cleared.
    if (running) begin
      if (at_end) begin
        counter_d = '0;
        clk_d     = ~clk_q;
      end else begin
        counter_d = counter_q + WIDTH'(1);
      end
    end else begin
      counter_d = '0;
      clk_d     = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (xfer && legal) active_d = div_value;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (xfer && legal) begin
          shadow_d = div_value;
          state_d  = PEND;
        end else if (!enable) begin
          state_d = STOP;
        end
      end
      PEND: begin
        if (boundary) begin
          active_d = shadow_q;
          state_d  = enable ? RUN : IDLE;
        end
      end
      STOP: begin
        // A value taken while stopping still waits for its own boundary.
        if (xfer && legal) begin
          shadow_d = div_value;
          state_d  = PEND;
        end else if (enable) begin
          state_d = RUN;
        end else if (boundary) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tick_d = clk_d && !clk_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      active_q  <= RESET_DIV;
      shadow_q  <= '0;
      counter_q <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      counter_q <= counter_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;
  assign busy    = running;

endmodule
